// File: rtl/pio_mem_fifo_n.sv
// pio_mem_fifo_n
// Token-read FIFO on the PCI_TRX PIO path. It stores request/ack beats together
// with their type flags and raises o_req while it holds anything. When the
// arbiter grants a token (i_tkn), the head entry is presented combinationally
// and popped at the end of that cycle. It also reports occupancy, almost-full,
// the high-water mark and a sticky underflow error.
//
// Handshake: a beat is accepted when (i_req_valid | i_ack_valid) & o_tready.
// o_tready depends only on registered state. A producer that sees o_tready=0
// holds its beat, and nothing happens until the beat is accepted. i_tkn is an
// unconditional pop request. When the FIFO is empty the pop is ignored and
// o_err_unf is set instead.
//
// Ports:
//   user_clk, reset_n               clock, async active-low reset
//   i_req_valid, i_ack_valid        write beat type flags (either one means a write)
//   i_data                          write data
//   o_tready                        FIFO can accept a beat this cycle
//   i_tkn                           token: pop head entry this cycle
//   o_req                           FIFO non-empty
//   o_req_valid, o_ack_valid, o_data  head entry, forced to zero when i_tkn=0
//   o_count, o_afull, o_max_count   occupancy, almost-full, peak occupancy
//   o_err_unf                       sticky underflow (token while empty)
//   i_clr_stat                      clears o_max_count (to current count) and o_err_unf
module pio_mem_fifo_n #(
    parameter int DATA_W   = 512,
    parameter int DEPTH    = 2,
    parameter int AFULL_TH = DEPTH - 1,
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              user_clk,
    input  logic              reset_n,
    input  logic              i_req_valid,
    input  logic              i_ack_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_tready,
    input  logic              i_tkn,
    output logic              o_req,
    output logic              o_req_valid,
    output logic              o_ack_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_afull,
    output logic [CNT_W-1:0]  o_max_count,
    output logic              o_err_unf,
    input  logic              i_clr_stat
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]  mem_req;
    logic [DEPTH-1:0]  mem_ack;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [CNT_W-1:0]  max_count;
    logic              err_unf;
    logic              push;
    logic              pop;
    logic              unf;
    logic              not_empty;
    logic              not_full;

    assign not_empty = (count != '0);
    assign not_full  = (count < CNT_W'(DEPTH));

    assign push = (i_req_valid | i_ack_valid) & not_full;
    assign pop  = i_tkn & not_empty;
    assign unf  = i_tkn & ~not_empty;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            mem_req <= '0;
            mem_ack <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr          <= wr_ptr + PTR_W'(1);
                mem_req[wr_ptr] <= i_req_valid;
                mem_ack[wr_ptr] <= i_ack_valid;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Data storage is not reset. Only the flags need a defined value.
    always_ff @(posedge user_clk) begin
        if (push) begin
            mem_data[wr_ptr] <= i_data;
        end
    end

    // A clear restarts the peak from the present occupancy. If the same cycle
    // also pushes, the post-edge count is taken so that the peak never trails
    // o_count. An underflow in the same cycle as a clear wins over the clear.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            max_count <= '0;
            err_unf   <= 1'b0;
        end else begin
            if (i_clr_stat) begin
                max_count <= (count_nxt > count) ? count_nxt : count;
                err_unf   <= unf;
            end else begin
                if (count_nxt > max_count) begin
                    max_count <= count_nxt;
                end
                if (unf) begin
                    err_unf <= 1'b1;
                end
            end
        end
    end

    assign o_tready    = not_full;
    assign o_req       = not_empty;
    assign o_count     = count;
    assign o_afull     = (count >= CNT_W'(AFULL_TH));
    assign o_max_count = max_count;
    assign o_err_unf   = err_unf;

    // Zero-latency read path: head entry is visible only while the token is high.
    assign o_req_valid = i_tkn & mem_req[rd_ptr];
    assign o_ack_valid = i_tkn & mem_ack[rd_ptr];
    assign o_data      = i_tkn ? mem_data[rd_ptr] : '0;

endmodule

// File: tb/tb_pio_mem_fifo_n.sv
module tb_pio_mem_fifo_n;

    localparam int DATA_W   = 16;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic              user_clk;
    logic              reset_n;
    logic              i_req_valid;
    logic              i_ack_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_tready;
    logic              i_tkn;
    logic              o_req;
    logic              o_req_valid;
    logic              o_ack_valid;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_count;
    logic              o_afull;
    logic [CNT_W-1:0]  o_max_count;
    logic              o_err_unf;
    logic              i_clr_stat;

    pio_mem_fifo_n #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AFULL_TH(AFULL_TH)
    ) dut (
        .user_clk   (user_clk),
        .reset_n    (reset_n),
        .i_req_valid(i_req_valid),
        .i_ack_valid(i_ack_valid),
        .i_data     (i_data),
        .o_tready   (o_tready),
        .i_tkn      (i_tkn),
        .o_req      (o_req),
        .o_req_valid(o_req_valid),
        .o_ack_valid(o_ack_valid),
        .o_data     (o_data),
        .o_count    (o_count),
        .o_afull    (o_afull),
        .o_max_count(o_max_count),
        .o_err_unf  (o_err_unf),
        .i_clr_stat (i_clr_stat)
    );

    // Clock and reset
    initial begin
        user_clk = 1'b0;
        forever #5 user_clk = ~user_clk;
    end

    // Reference model: a queue of {req, ack, data} entries plus status values
    logic [DATA_W+1:0] exp_q[$];
    int                exp_max;
    bit                exp_err;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_max = 0;
        exp_err = 1'b0;
    endtask

    task automatic check_status();
        int n;
        n = exp_q.size();
        chk("count",  64'(o_count),     64'(n));
        chk("tready", 64'(o_tready),    64'(n < DEPTH));
        chk("req",    64'(o_req),       64'(n != 0));
        chk("afull",  64'(o_afull),     64'(n >= AFULL_TH));
        chk("max",    64'(o_max_count), 64'(exp_max));
        chk("err",    64'(o_err_unf),   64'(exp_err));
    endtask

    // Drives one cycle, checks the pre-edge outputs, then advances the model.
    task automatic cycle(input bit req, input bit ack, input logic [DATA_W-1:0] data,
                         input bit tkn, input bit clr);
        logic [DATA_W+1:0] head;
        int  n_old;
        int  n_new;
        bit  push;
        bit  pop;
        bit  unf;
        @(negedge user_clk);
        i_req_valid = req;
        i_ack_valid = ack;
        i_data      = data;
        i_tkn       = tkn;
        i_clr_stat  = clr;
        #1;
        check_status();
        n_old = exp_q.size();
        if (!tkn) begin
            chk("idle_rv",   64'(o_req_valid), 64'(0));
            chk("idle_av",   64'(o_ack_valid), 64'(0));
            chk("idle_data", 64'(o_data),      64'(0));
        end else if (n_old != 0) begin
            head = exp_q[0];
            chk("head_rv",   64'(o_req_valid), 64'(head[DATA_W+1]));
            chk("head_av",   64'(o_ack_valid), 64'(head[DATA_W]));
            chk("head_data", 64'(o_data),      64'(head[DATA_W-1:0]));
        end
        push = (req || ack) && (n_old < DEPTH);
        pop  = tkn && (n_old > 0);
        unf  = tkn && (n_old == 0);
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back({req, ack, data});
        n_new = exp_q.size();
        if (clr) begin
            exp_max = (n_new > n_old) ? n_new : n_old;
            exp_err = unf;
        end else begin
            if (n_new > exp_max) exp_max = n_new;
            if (unf) exp_err = 1'b1;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n     = 1'b0;
        i_req_valid = 1'b0;
        i_ack_valid = 1'b0;
        i_data      = '0;
        i_tkn       = 1'b0;
        i_clr_stat  = 1'b0;
        model_reset();
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        reset_n = 1'b1;

        // Reset values
        idle();

        // Fill with A0..A3, no tokens
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DATA_W'(16'hA0 + i), 1'b0, 1'b0);
        idle();
        chk("full_count", 64'(o_count), 64'(4));
        chk("full_tready", 64'(o_tready), 64'(0));
        chk("full_max", 64'(o_max_count), 64'(4));

        // Drain in order
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("drained_req", 64'(o_req), 64'(0));

        // Steady push+pop at count 2 across pointer wrap
        cycle(1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0101, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DATA_W'(16'h0102 + i), 1'b1, 1'b0);
        idle();
        chk("steady_count", 64'(o_count), 64'(2));
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Underflow, then clear
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("unf_err", 64'(o_err_unf), 64'(1));
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle();
        chk("clr_err", 64'(o_err_unf), 64'(0));
        chk("clr_max", 64'(o_max_count), 64'(0));

        // Both flags set
        cycle(1'b1, 1'b1, 16'h0055, 1'b0, 1'b0);
        idle();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        idle();

        // Full with offer and token: offer refused, pop proceeds
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DATA_W'(16'h0200 + i), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h02FF, 1'b1, 1'b0);
        idle();
        chk("full_tkn_count", 64'(o_count), 64'(3));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Empty with push and token: push accepted, underflow flagged
        cycle(1'b1, 1'b0, 16'h0300, 1'b1, 1'b0);
        idle();
        chk("empty_push_count", 64'(o_count), 64'(1));
        chk("empty_push_err", 64'(o_err_unf), 64'(1));
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  DATA_W'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Reset mid-stream at count 3
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DATA_W'(16'h0400 + i), 1'b0, 1'b0);
        @(negedge user_clk);
        i_req_valid = 1'b0;
        i_ack_valid = 1'b0;
        i_tkn       = 1'b0;
        i_clr_stat  = 1'b0;
        reset_n     = 1'b0;
        model_reset();
        #1;
        check_status();
        chk("rst_data", 64'(o_data), 64'(0));
        @(negedge user_clk);
        reset_n = 1'b1;
        cycle(1'b1, 1'b0, 16'h0077, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
